// File: rtl/stage_wb_multi_if.sv
// Bundle between the memory stage, the deferred-return source and the writeback stage.
// The slave modport is the writeback stage's view of it.
interface stage_wb_multi_if #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int LANES = 2,
   localparam int RW   = $clog2(NREG)
);
   logic [LANES-1:0][XLEN-1:0] in_pc;
   logic [LANES-1:0][XLEN-1:0] in_res;
   logic [LANES-1:0][RW-1:0]   in_rd;
   logic [LANES-1:0]           in_w_rd;
   logic [LANES-1:0]           in_defer;
   logic [LANES-1:0]           in_bubble;
   logic                       ld_valid;
   logic [RW-1:0]              ld_rd;
   logic [XLEN-1:0]            ld_data;
   logic [LANES-1:0][XLEN-1:0] out_pc;
   logic [LANES-1:0][XLEN-1:0] out_res;
   logic [LANES-1:0][RW-1:0]   out_rd;
   logic [LANES-1:0]           out_w_rd;
   logic [LANES-1:0]           out_bubble;
   logic [NREG-1:0]            pending;
   logic [NREG-1:0][XLEN-1:0]  regs;
   logic [63:0]                instret;
   logic                       err_spurious;

   modport slave (
      input  in_pc, in_res, in_rd, in_w_rd, in_defer, in_bubble,
      input  ld_valid, ld_rd, ld_data,
      output out_pc, out_res, out_rd, out_w_rd, out_bubble,
      output pending, regs, instret, err_spurious
   );

   modport master (
      output in_pc, in_res, in_rd, in_w_rd, in_defer, in_bubble,
      output ld_valid, ld_rd, ld_data,
      input  out_pc, out_res, out_rd, out_w_rd, out_bubble,
      input  pending, regs, instret, err_spurious
   );
endinterface

// File: rtl/stage_wb_multi.sv
// Multi-lane writeback stage: latches retiring lanes, updates the register file,
// tracks registers awaiting late (deferred) results and counts retired instructions.
module stage_wb_multi #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int LANES   = 2,
   parameter int R0_ZERO = 1
) (
   input logic             clk,
   input logic             rst_n,
   stage_wb_multi_if.slave wb_io
);
   localparam int RW = $clog2(NREG);

   logic [LANES-1:0][XLEN-1:0] pc_q;
   logic [LANES-1:0][XLEN-1:0] res_q;
   logic [LANES-1:0][RW-1:0]   rd_q;
   logic [LANES-1:0]           w_rd_q;
   logic [LANES-1:0]           defer_q;
   logic [LANES-1:0]           bubble_q;

   logic [NREG-1:0][XLEN-1:0]  regs_q;
   logic [NREG-1:0][XLEN-1:0]  regs_d;
   logic [NREG-1:0]            pending_q;
   logic [NREG-1:0]            pending_d;
   logic [63:0]                instret_q;
   logic [63:0]                instret_d;
   logic                       err_q;
   logic                       err_d;

   logic [LANES-1:0]           rd_ok;
   logic [LANES-1:0]           wr_en;
   logic [LANES-1:0]           lane_wr;
   logic [LANES-1:0]           defer_set;
   logic                       ld_ok;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign rd_ok[gi]     = (R0_ZERO == 0) || (rd_q[gi] != '0);
         assign wr_en[gi]     = w_rd_q[gi] & ~bubble_q[gi] & ~defer_q[gi];
         assign lane_wr[gi]   = wr_en[gi] & rd_ok[gi];
         assign defer_set[gi] = w_rd_q[gi] & ~bubble_q[gi] & defer_q[gi] & rd_ok[gi];
      end
   endgenerate

   assign ld_ok = wb_io.ld_valid && ((R0_ZERO == 0) || (wb_io.ld_rd != '0));

   // Ordering gives priority: deferred return first, then lanes in ascending
   // order so the youngest lane's write lands last; scoreboard sets follow clears.
   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      err_d     = err_q;
      instret_d = instret_q;
      if (ld_ok) begin
         regs_d[wb_io.ld_rd] = wb_io.ld_data;
      end
      if (wb_io.ld_valid) begin
         pending_d[wb_io.ld_rd] = 1'b0;
         if (!pending_q[wb_io.ld_rd]) begin
            err_d = 1'b1;
         end
      end
      for (int i = 0; i < LANES; i++) begin
         if (lane_wr[i]) begin
            regs_d[rd_q[i]] = res_q[i];
         end
         if (defer_set[i]) begin
            pending_d[rd_q[i]] = 1'b1;
         end
         instret_d = instret_d + {63'd0, ~bubble_q[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         res_q     <= '0;
         rd_q      <= '0;
         w_rd_q    <= '0;
         defer_q   <= '0;
         bubble_q  <= '1;
         regs_q    <= '0;
         pending_q <= '0;
         instret_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pc_q      <= wb_io.in_pc;
         res_q     <= wb_io.in_res;
         rd_q      <= wb_io.in_rd;
         w_rd_q    <= wb_io.in_w_rd;
         defer_q   <= wb_io.in_defer;
         bubble_q  <= wb_io.in_bubble;
         regs_q    <= regs_d;
         pending_q <= pending_d;
         instret_q <= instret_d;
         err_q     <= err_d;
      end
   end

   assign wb_io.out_pc       = pc_q;
   assign wb_io.out_res      = res_q;
   assign wb_io.out_rd       = rd_q;
   assign wb_io.out_w_rd     = wr_en;
   assign wb_io.out_bubble   = bubble_q;
   assign wb_io.pending      = pending_q;
   assign wb_io.regs         = regs_q;
   assign wb_io.instret      = instret_q;
   assign wb_io.err_spurious = err_q;
endmodule

// File: tb/tb_stage_wb_multi.sv
// Directed bench for stage_wb_multi: the driver queues expected values tagged with
// the cycle they become visible; an independent monitor compares them on falling edges.
module tb_stage_wb_multi;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int LANES = 2;
   localparam int RW    = $clog2(NREG);

   localparam int K_REG  = 0;
   localparam int K_PBIT = 1;
   localparam int K_INST = 2;
   localparam int K_ERR  = 3;
   localparam int K_WRD  = 4;
   localparam int K_BUB  = 5;
   localparam int K_PALL = 6;
   localparam int K_RES  = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stage_wb_multi_if #(.XLEN(XLEN), .NREG(NREG), .LANES(LANES)) wb_if ();

   stage_wb_multi #(.XLEN(XLEN), .NREG(NREG), .LANES(LANES), .R0_ZERO(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb_io (wb_if)
   );

   typedef struct {
      int          cyc;
      string       name;
      int          kind;
      int          idx;
      logic [63:0] exp;
   } chk_t;

   chk_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] sample(int kind, int idx);
      case (kind)
         K_REG:   return 64'(wb_if.regs[idx]);
         K_PBIT:  return 64'(wb_if.pending[idx]);
         K_INST:  return wb_if.instret;
         K_ERR:   return 64'(wb_if.err_spurious);
         K_WRD:   return 64'(wb_if.out_w_rd);
         K_BUB:   return 64'(wb_if.out_bubble);
         K_PALL:  return 64'(wb_if.pending);
         K_RES:   return 64'(wb_if.out_res[idx]);
         default: return '1;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      logic [63:0] act;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            act = sample(sb_q[i].kind, sb_q[i].idx);
            n_checks++;
            if (act !== sb_q[i].exp) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h (cycle %0d)",
                        sb_q[i].name, act, sb_q[i].exp, cyc);
            end else begin
               $display("ok   %s: %h (cycle %0d)", sb_q[i].name, act, cyc);
            end
            sb_q.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_if.in_pc     = '0;
      wb_if.in_res    = '0;
      wb_if.in_rd     = '0;
      wb_if.in_w_rd   = '0;
      wb_if.in_defer  = '0;
      wb_if.in_bubble = '1;
      wb_if.ld_valid  = 1'b0;
      wb_if.ld_rd     = '0;
      wb_if.ld_data   = '0;
   endtask

   task automatic lane(input int l, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] res,
                       input logic [RW-1:0] rd, input logic w, input logic d);
      wb_if.in_pc[l]     = pc;
      wb_if.in_res[l]    = res;
      wb_if.in_rd[l]     = rd;
      wb_if.in_w_rd[l]   = w;
      wb_if.in_defer[l]  = d;
      wb_if.in_bubble[l] = 1'b0;
   endtask

   task automatic ld(input logic [RW-1:0] rd, input logic [XLEN-1:0] data);
      wb_if.ld_valid = 1'b1;
      wb_if.ld_rd    = rd;
      wb_if.ld_data  = data;
   endtask

   task automatic expect_at(input int dly, input string nm, input int kind, input int idx,
                            input logic [63:0] v);
      sb_q.push_back('{cyc + dly, nm, kind, idx, v});
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // Idle after reset
      repeat (5) step();
      n_checks++;
      if (wb_if.regs[3] !== 32'd0) begin
         n_fail++;
         $display("FAIL direct_idle_reg3: got %h", wb_if.regs[3]);
      end else begin
         $display("ok   direct_idle_reg3: %h", wb_if.regs[3]);
      end
      n_checks++;
      if (wb_if.instret !== 64'd0) begin
         n_fail++;
         $display("FAIL direct_idle_instret: got %h", wb_if.instret);
      end else begin
         $display("ok   direct_idle_instret: %h", wb_if.instret);
      end
      n_checks++;
      if (wb_if.pending !== '0) begin
         n_fail++;
         $display("FAIL direct_idle_pending: got %h", wb_if.pending);
      end else begin
         $display("ok   direct_idle_pending: %h", wb_if.pending);
      end
      n_checks++;
      if (wb_if.out_w_rd !== '0) begin
         n_fail++;
         $display("FAIL direct_idle_w_rd: got %h", wb_if.out_w_rd);
      end else begin
         $display("ok   direct_idle_w_rd: %h", wb_if.out_w_rd);
      end
      n_checks++;
      if (wb_if.out_bubble !== '1) begin
         n_fail++;
         $display("FAIL direct_idle_bubble: got %h", wb_if.out_bubble);
      end else begin
         $display("ok   direct_idle_bubble: %h", wb_if.out_bubble);
      end
      expect_at(0, "idle_reg3",    K_REG,  3, 64'd0);
      expect_at(0, "idle_instret", K_INST, 0, 64'd0);
      expect_at(0, "idle_w_rd",    K_WRD,  0, 64'd0);
      expect_at(0, "idle_pending", K_PALL, 0, 64'd0);
      expect_at(0, "idle_bubble",  K_BUB,  0, 64'd3);
      expect_at(0, "idle_err",     K_ERR,  0, 64'd0);

      // Both lanes write rd 3: lane 1 wins
      lane(0, 32'h100, 32'hAAAA, 5'd3, 1'b1, 1'b0);
      lane(1, 32'h104, 32'h5555, 5'd3, 1'b1, 1'b0);
      expect_at(1, "dual_w_rd",          K_WRD,  0, 64'd3);
      expect_at(1, "lane0_res",          K_RES,  0, 64'hAAAA);
      expect_at(2, "same_rd_lane1_wins", K_REG,  3, 64'h5555);
      expect_at(2, "instret_2",          K_INST, 0, 64'd2);
      step();
      idle();

      // Write to r0 is dropped but still retires
      lane(0, 32'h108, 32'hFFFF, 5'd0, 1'b1, 1'b0);
      expect_at(1, "r0_w_rd",   K_WRD,  0, 64'd1);
      expect_at(2, "r0_zero",   K_REG,  0, 64'd0);
      expect_at(2, "instret_3", K_INST, 0, 64'd3);
      step();
      idle();

      // Deferred write to rd 7
      lane(0, 32'h10C, 32'hDEAD, 5'd7, 1'b1, 1'b1);
      expect_at(1, "defer_w_rd",     K_WRD,  0, 64'd0);
      expect_at(1, "pend7_early",    K_PBIT, 7, 64'd0);
      expect_at(2, "pend7_set",      K_PBIT, 7, 64'd1);
      expect_at(2, "defer_no_write", K_REG,  7, 64'd0);
      expect_at(2, "instret_4",      K_INST, 0, 64'd4);
      step();
      idle();
      step();
      ld(5'd7, 32'h1234);
      expect_at(1, "ld_reg7",   K_REG,  7, 64'h1234);
      expect_at(1, "ld_clr7",   K_PBIT, 7, 64'd0);
      expect_at(1, "ld_no_err", K_ERR,  0, 64'd0);
      step();
      idle();

      // Return to rd 7 lands in the same cycle a newer defer to rd 7 latches
      lane(0, 32'h110, 32'h0, 5'd7, 1'b1, 1'b1);
      step();
      idle();
      lane(1, 32'h114, 32'h0, 5'd7, 1'b1, 1'b1);
      step();
      idle();
      ld(5'd7, 32'h4321);
      expect_at(1, "set_beats_clr", K_PBIT, 7, 64'd1);
      expect_at(1, "ld_reg7b",      K_REG,  7, 64'h4321);
      expect_at(1, "no_err_b",      K_ERR,  0, 64'd0);
      expect_at(1, "instret_6",     K_INST, 0, 64'd6);
      step();
      idle();

      // Spurious return to rd 9
      ld(5'd9, 32'h9999);
      expect_at(1, "spur_reg9", K_REG, 9, 64'h9999);
      expect_at(1, "spur_err",  K_ERR, 0, 64'd1);
      step();
      idle();

      // Lane write beats a return to the same register
      lane(0, 32'h118, 32'h7777, 5'd9, 1'b1, 1'b0);
      step();
      idle();
      ld(5'd9, 32'h8888);
      expect_at(1, "lane_beats_ld", K_REG,  9, 64'h7777);
      expect_at(1, "err_sticky",    K_ERR,  0, 64'd1);
      expect_at(1, "instret_7",     K_INST, 0, 64'd7);
      step();
      idle();

      // Build pending[5] and instret = 40, then reset mid-stream
      lane(0, 32'h11C, 32'h0, 5'd5, 1'b1, 1'b1);
      step();
      idle();
      for (int k = 0; k < 16; k++) begin
         lane(0, 32'h200 + 32'(8 * k), 32'h0, 5'd1, 1'b0, 1'b0);
         lane(1, 32'h204 + 32'(8 * k), 32'h0, 5'd2, 1'b0, 1'b0);
         step();
      end
      idle();
      step();
      expect_at(0, "pre_rst_instret", K_INST, 0, 64'd40);
      expect_at(0, "pre_rst_pend5",   K_PBIT, 5, 64'd1);
      lane(0, 32'h300, 32'hBEEF, 5'd3, 1'b1, 1'b0);
      lane(1, 32'h304, 32'hCAFE, 5'd4, 1'b1, 1'b0);
      step();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (wb_if.pending !== '0) begin
         n_fail++;
         $display("FAIL direct_rst_pending: got %h", wb_if.pending);
      end else begin
         $display("ok   direct_rst_pending: %h", wb_if.pending);
      end
      n_checks++;
      if (wb_if.instret !== 64'd0) begin
         n_fail++;
         $display("FAIL direct_rst_instret: got %h", wb_if.instret);
      end else begin
         $display("ok   direct_rst_instret: %h", wb_if.instret);
      end
      n_checks++;
      if (wb_if.out_bubble !== '1) begin
         n_fail++;
         $display("FAIL direct_rst_bubble: got %h", wb_if.out_bubble);
      end else begin
         $display("ok   direct_rst_bubble: %h", wb_if.out_bubble);
      end
      expect_at(0, "rst_pending", K_PALL, 0, 64'd0);
      expect_at(0, "rst_instret", K_INST, 0, 64'd0);
      expect_at(0, "rst_bubble",  K_BUB,  0, 64'd3);
      expect_at(0, "rst_reg3",    K_REG,  3, 64'd0);
      expect_at(0, "rst_err",     K_ERR,  0, 64'd0);
      idle();
      step();
      step();
      rst_n = 1'b1;
      step();
      step();

      foreach (sb_q[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: never checked, expected %h at cycle %0d",
                  sb_q[i].name, sb_q[i].exp, sb_q[i].cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stage_wb_multi.md
Name: stage_wb_multi

Overview:
- Parametrised writeback stage: retires LANES results per cycle into the architectural register file.
- Supports deferred (late-returning, e.g. load) writes through a pending-register scoreboard and a separate return port.
- Counts retired instructions and drives registered per-lane writeback state to the forwarding/hazard logic.
- Sits after the memory stage; it is the last pipeline stage.

Parameters:
- XLEN, 32, data and PC width.
- NREG, 32, number of architectural registers; index width RW = clog2(NREG).
- LANES, 2, retire lanes per cycle; lane LANES-1 is the youngest.
- R0_ZERO, 1, when 1 register 0 is never written and never marked pending.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_pc  in  LANES x XLEN  per-lane PC from the memory stage.
- in_res  in  LANES x XLEN  per-lane result.
- in_rd  in  LANES x RW  per-lane destination register.
- in_w_rd  in  LANES  per-lane write enable.
- in_defer  in  LANES  result arrives later on the ld_* port; no data is written now.
- in_bubble  in  LANES  lane carries no instruction.
- ld_valid  in  1  deferred result return strobe.
- ld_rd  in  RW  deferred return destination.
- ld_data  in  XLEN  deferred return data.
- out_pc  out  LANES x XLEN  latched PC.
- out_res  out  LANES x XLEN  latched result.
- out_rd  out  LANES x RW  latched rd.
- out_w_rd  out  LANES  latched w_rd AND NOT bubble AND NOT defer.
- out_bubble  out  LANES  latched bubble.
- pending  out  NREG  scoreboard, one bit per register awaiting a deferred result.
- regs  out  NREG x XLEN  architectural register file.
- instret  out  64  retired-instruction count.
- err_spurious  out  1  sticky; set when a return hits a non-pending register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All latched bubble bits = 1; latched pc/res/rd/w_rd/defer = 0.
  - regs all 0; pending = 0; instret = 0; err_spurious = 0.
  - Reset mid-operation discards in-flight lanes and pending state.
- Capture: every posedge, each lane's in_* is latched unconditionally; latched bubble = in_bubble. No stall input; the upstream stage inserts bubbles.
- out_* are combinational from the latched values, so they are valid the cycle after capture.
- Register write, at the posedge following capture, from latched values:
  - Lane i writes regs[rd_i] <= res_i iff out_w_rd[i] is set and (R0_ZERO = 0 or rd_i != 0).
- Deferred return: ld_valid writes regs[ld_rd] <= ld_data at the posedge, subject to the R0_ZERO rule.
- Same-rd conflicts within one cycle:
  - Between lanes, the highest-index lane wins.
  - Any lane write beats a deferred return to the same register.
- Scoreboard:
  - A latched lane with !bubble, w_rd and defer sets pending[rd] (not for rd 0 when R0_ZERO).
  - ld_valid clears pending[ld_rd].
  - A set and a clear of the same bit in one cycle: set wins, because a newer deferred op owns the register.
  - ld_valid with pending[ld_rd] = 0: the write still occurs and err_spurious is set; it clears only on reset.
- instret:
  - instret <= instret + popcount(!latched bubble) each cycle, wrapping mod 2^64.
  - Deferred lanes count at retire, not at return.
- Writes have no combinational path from in_* to regs; regfile read-after-write bypass is the consumer's job.

Test Plan:
- Reset then idle (all in_bubble = 1) for 5 cycles -> regs all 0, instret = 0, out_w_rd = 0, pending = 0.
- Lane0 rd = 3, res = 0xAAAA and lane1 rd = 3, res = 0x5555, both w_rd -> after 2 edges regs[3] = 0x5555 and instret = 2.
- Lane0 rd = 0, res = 0xFFFF, w_rd, with R0_ZERO = 1 -> regs[0] stays 0 while instret still increments.
- Lane0 defer, rd = 7:
  - pending[7] = 1 one edge after the latched cycle.
  - Then ld_valid, ld_rd = 7, ld_data = 0x1234 -> regs[7] = 0x1234 and pending[7] = 0.
  - Same cycle as a new defer to rd 7 -> pending[7] stays 1.
- ld_valid to rd 9 with pending[9] = 0 -> regs[9] is written and err_spurious = 1 until reset. A lane write to rd 9 in the same cycle overrides ld_data.
- Assert rst_n low mid-stream with pending[5] = 1 and instret = 40 -> immediately pending = 0, instret = 0, out_bubble = all 1s.
